fib_tx_frame_sched: RTL and testbench
=====================================

// Module: fib_tx_frame_sched
// PURPOSE
//  Read-side sequencer for the TX bridge FIFOs (txwbcnt_fifo + txdata_fifo) filled by the AXIS TX write side.
//  Pops one byte count, then exactly ceil(bcnt/8) data words, and presents them as one framed burst
//  (sop/eop/mod) to the MAC TX datapath. Enforces min/max frame length (drains bad frames) and a minimum inter-frame gap.
// PARAMETERS
//  DATA_WIDTH   64    data word width (fixed 64; mod encoding assumes 8 bytes/word)
//  BCNT_WIDTH   32    width of byte-count FIFO entry
//  MIN_BYTES    14    smallest frame forwarded; smaller -> dropped
//  MAX_BYTES    1518  largest frame forwarded; larger -> dropped
//  IFG_CYCLES   3     idle clk cycles forced after every eop accept or drop completion (0 = none)
// PORTS
//  clk              in   1           single clock, both FIFO read ports and MAC side
//  reset_           in   1           asynchronous, active-low reset
//  enable           in   1           0: no new frame started; frame in progress completes
//  txwbcnt_rdreq    out  1           pop byte-count FIFO
//  txwbcnt_rddata   in   BCNT_WIDTH  byte count, valid 1 clk after rdreq (non-FWFT)
//  txwbcnt_rdempty  in   1           byte-count FIFO empty
//  txdata_rdreq     out  1           pop data FIFO
//  txdata_rddata    in   DATA_WIDTH  data word, valid 1 clk after rdreq (non-FWFT)
//  txdata_rdempty   in   1           data FIFO empty
//  mac_tx_data      out  DATA_WIDTH  frame word, byte 0 in [7:0]
//  mac_tx_valid     out  1           word valid
//  mac_tx_sop       out  1           first word of frame
//  mac_tx_eop       out  1           last word of frame
//  mac_tx_mod       out  3           valid bytes in eop word, 0 = all 8; 0 when !eop
//  mac_tx_ready     in   1           MAC accepts word when valid&ready
//  stat_frames_sent out  32          frames whose eop was accepted; wraps at 2^32-1 -> 0
//  stat_frames_drop out  32          frames dropped (bcnt 0, <MIN, >MAX); wraps
//  tx_underrun      out  1           1-clk pulse: data FIFO empty while words still owed mid-frame
// BEHAVIOUR
//  Reset (async assert, sync deassert use): all outputs 0, state IDLE, counters 0, skid buffer empty.
//  States (one-hot): IDLE, BCNT_WAIT, XFER, DROP, IFG.
//  IDLE: enable & !txwbcnt_rdempty -> txwbcnt_rdreq=1 for exactly 1 clk -> BCNT_WAIT.
//  BCNT_WAIT (1 clk): latch bcnt; words_left = (bcnt+7)>>3 (16-bit, bcnt[BCNT_WIDTH-1:16]!=0 counts as >MAX);
//   mod_last = bcnt[2:0].  bcnt==0 -> drop++ -> IFG (no data popped). bcnt<MIN or >MAX -> DROP. else -> XFER.
//  XFER: txdata_rdreq = !txdata_rdempty & (words_req_left!=0) & (skid occupancy + reads in flight < 2).
//   Each returned word enters 2-entry skid buffer; head drives mac_tx_*. First word: sop=1. Word with
//   words_left==1: eop=1, mod=mod_last. words_left decrements on valid&ready. eop accepted -> sent++ -> IFG.
//   mac_tx_valid/data/sop/eop/mod held stable while valid & !ready. Valid may drop between words only on underrun.
//  Underrun: in XFER, words_req_left!=0 & txdata_rdempty & skid empty & none in flight -> tx_underrun pulse
//   (once per bubble start), wait; no frame truncation.
//  DROP: txdata_rdreq = !txdata_rdempty each clk until ceil(bcnt/8) words popped; mac_tx_valid=0; drop++ -> IFG.
//  IFG: count IFG_CYCLES clks (skip if 0) -> IDLE. Back-to-back frames: sop no earlier than 1+IFG_CYCLES+2 clk after eop.
//  enable deasserted: only IDLE is gated; XFER/DROP/IFG run to completion.
//  Simultaneous: never rdreq on both FIFOs same clk; counters saturate never (wrap).
//  Byte count FIFO is never popped when empty; data FIFO never popped when empty (rdreq gated by rdempty, no exceptions).
//  Reset mid-frame: immediate return to IDLE; FIFO contents are cleared by the same reset externally.
// STRUCTURE
//  Shared include fib_tx_defs.vh: state one-hot localparams, MOD_FULL=3'd0, BYTES_PER_WORD=8.
//  Sub-module fib_tx_skid_buf: 2-entry buffer {data,sop,eop,mod}, in_valid / out_valid / out_ready, occupancy out.
//  Top: FSM, word/req counters, in-flight flag, IFG counter, stats counters.
// TESTING
//  bcnt=64, 8 words queued, ready=1 -> 8 valid clk, sop on w0, eop on w7, mod=0; sent=1.
//  bcnt=61 -> 8 words, eop word mod=5; ready toggled 1/0 each clk -> data stable while stalled, no loss/dup.
//  bcnt=2000, 250 words -> mac_tx_valid never 1, 250 data pops, drop=1; next bcnt=60 frame sent normally.
//  bcnt=0 then bcnt=8 -> no data pop for first, drop=1; second frame 1 word sop=eop=1, mod=0.
//  bcnt=64, only 3 words present, rest after 20 clk -> single tx_underrun pulse, frame completes intact.
//  Two 60-byte frames, IFG_CYCLES=3 -> gap eop->sop >= 6 clk; reset_ low mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/fib_tx_frame_sched_pkg.sv
// Purpose: shared constants, FSM state encoding and skid-entry type for the TX frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none.
package fib_tx_frame_sched_pkg;

  localparam int         DATA_WIDTH     = 64;
  localparam int         BCNT_WIDTH     = 32;
  localparam int         BYTES_PER_WORD = 8;
  localparam logic [2:0] MOD_FULL       = 3'd0;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_BCNT_WAIT = 5'b00010,
    ST_XFER      = 5'b00100,
    ST_DROP      = 5'b01000,
    ST_IFG       = 5'b10000
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [2:0]            mod;
  } skid_entry_t;

  // ceil(bytes/8) on the low 16 bits; a 17-bit sum keeps the carry for 0xFFF9..0xFFFF.
  function automatic logic [15:0] words_for_bytes(input logic [15:0] bytes);
    logic [16:0] sum;
    sum = {1'b0, bytes} + 17'(BYTES_PER_WORD - 1);
    return {2'b00, sum[16:3]};
  endfunction

endpackage

// File: rtl/fib_tx_frame_sched_if.sv
// Purpose: bundles the two FIFO read ports and the MAC TX word stream of the frame scheduler.
// Latency: n/a (wiring only). Backpressure: mac_tx_ready stalls the MAC side; FIFOs are non-FWFT.
// Modports: master = scheduler (pops FIFOs, drives MAC), slave = FIFO/MAC environment.
interface fib_tx_frame_sched_if;
  import fib_tx_frame_sched_pkg::*;

  logic                  txwbcnt_rdreq;
  logic [BCNT_WIDTH-1:0] txwbcnt_rddata;
  logic                  txwbcnt_rdempty;
  logic                  txdata_rdreq;
  logic [DATA_WIDTH-1:0] txdata_rddata;
  logic                  txdata_rdempty;
  logic [DATA_WIDTH-1:0] mac_tx_data;
  logic                  mac_tx_valid;
  logic                  mac_tx_sop;
  logic                  mac_tx_eop;
  logic [2:0]            mac_tx_mod;
  logic                  mac_tx_ready;

  modport master (
    output txwbcnt_rdreq, input txwbcnt_rddata, input txwbcnt_rdempty,
    output txdata_rdreq,  input txdata_rddata,  input txdata_rdempty,
    output mac_tx_data, output mac_tx_valid, output mac_tx_sop,
    output mac_tx_eop,  output mac_tx_mod,   input  mac_tx_ready
  );

  modport slave (
    input  txwbcnt_rdreq, output txwbcnt_rddata, output txwbcnt_rdempty,
    input  txdata_rdreq,  output txdata_rddata,  output txdata_rdempty,
    input  mac_tx_data, input mac_tx_valid, input mac_tx_sop,
    input  mac_tx_eop,  input mac_tx_mod,   output mac_tx_ready
  );

endinterface

// File: rtl/fib_tx_frame_sched_skid_buf.sv
// Purpose: 2-entry word buffer between the data FIFO read port and the MAC; head drives the output.
// Latency: 1 clk from in_valid_i to out_valid_o. Backpressure: none on input (caller keeps
// occupancy + in-flight <= 2); output holds head stable while out_ready_i is low.
// Ports: clk/reset_, in_valid_i/in_entry_i, out_ready_i, out_valid_o/out_entry_o, occ_o (0..2).
module fib_tx_skid_buf
  import fib_tx_frame_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset_,
  input  logic        in_valid_i,
  input  skid_entry_t in_entry_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output skid_entry_t out_entry_o,
  output logic [1:0]  occ_o
);

  skid_entry_t head_q;
  skid_entry_t tail_q;
  logic [1:0]  occ_q;
  logic        pop;

  assign out_valid_o = (occ_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  // Masked so sop/eop/mod/data all read 0 whenever nothing is presented.
  assign out_entry_o = out_valid_o ? head_q : '0;
  assign occ_o       = occ_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({in_valid_i, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= in_entry_i;
          else               tail_q <= in_entry_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= in_entry_i;
          end else begin
            head_q <= tail_q;
            tail_q <= in_entry_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fib_tx_frame_sched.sv
// Purpose: pops a byte count then ceil(bcnt/8) data words, emits them as one sop/eop/mod burst,
// drops out-of-range frames, and forces an inter-frame gap. Latency: bcnt pop to sop = 4 clk.
// Backpressure: mac_tx_ready low holds the word; data reads throttle to the 2-entry skid buffer.
// Ports: clk, reset_ (async, active low), enable, tx (FIFO read + MAC stream), stat_frames_*, tx_underrun.
module fib_tx_frame_sched
  import fib_tx_frame_sched_pkg::*;
#(
  parameter int MIN_BYTES  = 14,
  parameter int MAX_BYTES  = 1518,
  parameter int IFG_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 enable,
  fib_tx_frame_sched_if.master tx,
  output logic [31:0]          stat_frames_sent,
  output logic [31:0]          stat_frames_drop,
  output logic                 tx_underrun
);

  localparam state_e     POST_ST  = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
  localparam logic [7:0] IFG_LOAD = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

  state_e      state_q;
  logic        armed_q;      // low during reset and the first clk after, so IDLE never pops in reset
  logic [15:0] req_left_q;   // data words still to be popped from the FIFO
  logic [15:0] push_left_q;  // data words still to enter the skid buffer (drives eop tagging)
  logic        sop_pend_q;
  logic [2:0]  mod_last_q;
  logic        inflight_q;   // a transfer read issued last clk returns this clk
  logic        bubble_q;
  logic        underrun_q;
  logic [7:0]  ifg_cnt_q;
  logic [31:0] sent_q;
  logic [31:0] drop_q;

  logic [BCNT_WIDTH-1:0] bcnt;
  logic [15:0]           bcnt_words;
  logic                  bcnt_bad;
  logic                  bcnt_rd, xfer_rd, drop_rd, data_rd;
  logic                  underrun_cond, eop_acc;
  skid_entry_t           skid_in, skid_out;
  logic                  skid_vld, skid_pop;
  logic [1:0]            skid_occ;
  logic [2:0]            skid_fill;

  assign bcnt       = tx.txwbcnt_rddata;
  assign bcnt_words = words_for_bytes(bcnt[15:0]);
  // Full-width compare, so any bit above 15 set also lands in the >MAX case.
  assign bcnt_bad   = (bcnt < BCNT_WIDTH'(MIN_BYTES)) | (bcnt > BCNT_WIDTH'(MAX_BYTES));

  // Fill counts the head as gone when it is accepted this clk; that keeps one read in flight
  // per clk during a ready stream, so valid stays high back to back with only two entries.
  assign skid_pop  = skid_vld & tx.mac_tx_ready;
  assign skid_fill = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, skid_pop};

  // Read requests are combinational: they must see the current rdempty to never pop an empty FIFO.
  assign bcnt_rd = (state_q == ST_IDLE) & armed_q & enable & ~tx.txwbcnt_rdempty;
  assign xfer_rd = (state_q == ST_XFER) & ~tx.txdata_rdempty & (req_left_q != 16'd0) & (skid_fill < 3'd2);
  assign drop_rd = (state_q == ST_DROP) & ~tx.txdata_rdempty & (req_left_q != 16'd0);
  assign data_rd = xfer_rd | drop_rd;

  assign underrun_cond = (state_q == ST_XFER) & (req_left_q != 16'd0) & tx.txdata_rdempty
                       & (skid_occ == 2'd0) & ~inflight_q;
  assign eop_acc       = skid_pop & skid_out.eop;

  assign skid_in.data = tx.txdata_rddata;
  assign skid_in.sop  = sop_pend_q;
  assign skid_in.eop  = (push_left_q == 16'd1);
  assign skid_in.mod  = (push_left_q == 16'd1) ? mod_last_q : MOD_FULL;

  fib_tx_skid_buf u_skid (
    .clk        (clk),
    .reset_     (reset_),
    .in_valid_i (inflight_q),
    .in_entry_i (skid_in),
    .out_ready_i(tx.mac_tx_ready),
    .out_valid_o(skid_vld),
    .out_entry_o(skid_out),
    .occ_o      (skid_occ)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      req_left_q  <= 16'd0;
      push_left_q <= 16'd0;
      sop_pend_q  <= 1'b0;
      mod_last_q  <= 3'd0;
      inflight_q  <= 1'b0;
      bubble_q    <= 1'b0;
      underrun_q  <= 1'b0;
      ifg_cnt_q   <= 8'd0;
      sent_q      <= 32'd0;
      drop_q      <= 32'd0;
    end else begin
      armed_q    <= 1'b1;
      inflight_q <= xfer_rd;
      bubble_q   <= underrun_cond;
      underrun_q <= underrun_cond & ~bubble_q;
      if (data_rd) req_left_q <= req_left_q - 16'd1;
      if (inflight_q) begin
        push_left_q <= push_left_q - 16'd1;
        sop_pend_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (bcnt_rd) state_q <= ST_BCNT_WAIT;
        ST_BCNT_WAIT: begin
          mod_last_q  <= bcnt[2:0];
          req_left_q  <= bcnt_words;
          push_left_q <= bcnt_words;
          sop_pend_q  <= 1'b1;
          if (bcnt == '0) begin
            drop_q    <= drop_q + 32'd1;
            state_q   <= POST_ST;
            ifg_cnt_q <= IFG_LOAD;
          end else if (bcnt_bad) begin
            state_q <= ST_DROP;
          end else begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: if (eop_acc) begin
          sent_q    <= sent_q + 32'd1;
          state_q   <= POST_ST;
          ifg_cnt_q <= IFG_LOAD;
        end
        ST_DROP: if (drop_rd && req_left_q == 16'd1) begin
          drop_q    <= drop_q + 32'd1;
          state_q   <= POST_ST;
          ifg_cnt_q <= IFG_LOAD;
        end
        ST_IFG: begin
          if (ifg_cnt_q == 8'd0) state_q <= ST_IDLE;
          else                   ifg_cnt_q <= ifg_cnt_q - 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx.txwbcnt_rdreq = bcnt_rd;
  assign tx.txdata_rdreq  = data_rd;
  assign tx.mac_tx_valid  = skid_vld;
  assign tx.mac_tx_data   = skid_out.data;
  assign tx.mac_tx_sop    = skid_out.sop;
  assign tx.mac_tx_eop    = skid_out.eop;
  assign tx.mac_tx_mod    = skid_out.mod;
  assign stat_frames_sent = sent_q;
  assign stat_frames_drop = drop_q;
  assign tx_underrun      = underrun_q;

endmodule

// File: tb/tb_fib_tx_frame_sched.sv
// Purpose: directed bench for fib_tx_frame_sched with non-FWFT FIFO models and a MAC-side monitor.
// Latency: n/a. Backpressure: mac_tx_ready driven by the stimulus (held high or toggled).
// Ports: none (top-level bench).
module tb_fib_tx_frame_sched;
  import fib_tx_frame_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] stat_sent, stat_drop;
  logic        tx_underrun;

  fib_tx_frame_sched_if ifc();

  fib_tx_frame_sched #(.MIN_BYTES(8), .MAX_BYTES(1518), .IFG_CYCLES(3)) dut (
    .clk(clk), .reset_(reset_), .enable(enable), .tx(ifc),
    .stat_frames_sent(stat_sent), .stat_frames_drop(stat_drop), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // Non-FWFT FIFO models; reset discards whatever is still queued.
  logic [63:0] dmem [0:1023];
  logic [31:0] bmem [0:63];
  int dwr = 0, drd = 0, bwr = 0, brd = 0;
  assign ifc.txdata_rdempty  = (drd == dwr);
  assign ifc.txwbcnt_rdempty = (brd == bwr);

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      drd <= dwr;
      brd <= bwr;
      ifc.txdata_rddata  <= '0;
      ifc.txwbcnt_rddata <= '0;
    end else begin
      if (ifc.txdata_rdreq && drd != dwr) begin
        ifc.txdata_rddata <= dmem[drd];
        drd <= drd + 1;
      end
      if (ifc.txwbcnt_rdreq && brd != bwr) begin
        ifc.txwbcnt_rddata <= bmem[brd];
        brd <= brd + 1;
      end
    end
  end

  // Monitor: records accepted words and counts events at the falling edge.
  int cyc = 0, acc_n = 0, vld_n = 0, dpop_n = 0, bpop_n = 0, und_n = 0, viol_n = 0, stall_viol_n = 0;
  logic [63:0] acc_data [0:127];
  logic        acc_sop  [0:127];
  logic        acc_eop  [0:127];
  logic [2:0]  acc_mod  [0:127];
  int          acc_cyc  [0:127];
  logic        p_stall = 1'b0;
  logic [63:0] p_data = '0;
  logic        p_sop = 1'b0, p_eop = 1'b0;
  logic [2:0]  p_mod = 3'd0;

  always @(negedge clk) begin
    cyc++;
    if (ifc.mac_tx_valid) vld_n++;
    if (ifc.mac_tx_valid && ifc.mac_tx_ready && acc_n < 128) begin
      acc_data[acc_n] = ifc.mac_tx_data;
      acc_sop[acc_n]  = ifc.mac_tx_sop;
      acc_eop[acc_n]  = ifc.mac_tx_eop;
      acc_mod[acc_n]  = ifc.mac_tx_mod;
      acc_cyc[acc_n]  = cyc;
      acc_n++;
    end
    if (ifc.txdata_rdreq) dpop_n++;
    if (ifc.txwbcnt_rdreq) bpop_n++;
    if (tx_underrun) und_n++;
    if ((ifc.txdata_rdreq && ifc.txdata_rdempty) || (ifc.txwbcnt_rdreq && ifc.txwbcnt_rdempty) ||
        (ifc.txdata_rdreq && ifc.txwbcnt_rdreq)) viol_n++;
    if (p_stall && !(ifc.mac_tx_valid && ifc.mac_tx_data == p_data && ifc.mac_tx_sop == p_sop &&
                     ifc.mac_tx_eop == p_eop && ifc.mac_tx_mod == p_mod)) stall_viol_n++;
    p_stall = ifc.mac_tx_valid && !ifc.mac_tx_ready;
    p_data  = ifc.mac_tx_data;
    p_sop   = ifc.mac_tx_sop;
    p_eop   = ifc.mac_tx_eop;
    p_mod   = ifc.mac_tx_mod;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int tag, input int idx);
    return {16'hC0DE, 16'(tag), 32'(idx)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      dmem[dwr] = mkword(tag, first + i);
      dwr++;
    end
  endtask

  task automatic push_bcnt(input logic [31:0] v);
    bmem[bwr] = v;
    bwr++;
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (acc_n < target && k < budget) begin
      step(1);
      k++;
    end
    check({tag, "_done"}, 64'(acc_n >= target), 64'd1);
  endtask

  task automatic check_frame(input int first, input int n, input int tag, input logic [2:0] mod_exp);
    for (int i = 0; i < n; i++) begin
      check($sformatf("f%0d_w%0d_data", tag, i), acc_data[first + i], mkword(tag, i));
      check($sformatf("f%0d_w%0d_sop_eop_mod", tag, i),
            64'({acc_sop[first + i], acc_eop[first + i], acc_mod[first + i]}),
            64'({i == 0, i == n - 1, (i == n - 1) ? mod_exp : 3'd0}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, p0, b0, u0, base;
    ifc.mac_tx_ready = 1'b0;
    step(3);
    // Reset state
    check("rst_mac_flags", 64'({ifc.mac_tx_valid, ifc.mac_tx_sop, ifc.mac_tx_eop, ifc.mac_tx_mod}), 64'd0);
    check("rst_mac_data", ifc.mac_tx_data, 64'd0);
    check("rst_rdreq", 64'({ifc.txwbcnt_rdreq, ifc.txdata_rdreq}), 64'd0);
    check("rst_stats", {stat_sent, stat_drop}, 64'd0);
    check("rst_underrun", 64'(tx_underrun), 64'd0);
    reset_ = 1'b1;
    enable = 1'b1;
    ifc.mac_tx_ready = 1'b1;
    step(2);

    // T1: 64-byte frame, ready held high: 8 back-to-back words, mod 0
    v0 = vld_n;
    push_words(1, 0, 8);
    push_bcnt(32'd64);
    wait_acc(8, 100, "t1");
    step(3);
    check_frame(0, 8, 1, 3'd0);
    check("t1_burst_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    check("t1_valid_clks", 64'(vld_n - v0), 64'd8);
    check("t1_sent", 64'(stat_sent), 64'd1);

    // T2: 61-byte frame with ready toggling every clk
    push_words(2, 0, 8);
    push_bcnt(32'd61);
    for (int k = 0; k < 300 && acc_n < 16; k++) begin
      ifc.mac_tx_ready = ~ifc.mac_tx_ready;
      step(1);
    end
    check("t2_done", 64'(acc_n >= 16), 64'd1);
    ifc.mac_tx_ready = 1'b1;
    step(3);
    check_frame(8, 8, 2, 3'd5);
    check("t2_stall_stable", 64'(stall_viol_n), 64'd0);
    check("t2_sent", 64'(stat_sent), 64'd2);

    // T3: 2000-byte frame dropped (250 pops, no valid), then a 60-byte frame
    p0 = dpop_n;
    v0 = vld_n;
    push_words(3, 0, 250);
    push_words(4, 0, 8);
    push_bcnt(32'd2000);
    push_bcnt(32'd60);
    wait_acc(24, 700, "t3");
    step(3);
    check("t3_data_pops", 64'(dpop_n - p0), 64'd258);
    check("t3_valid_clks", 64'(vld_n - v0), 64'd8);
    check("t3_drop", 64'(stat_drop), 64'd1);
    check("t3_sent", 64'(stat_sent), 64'd3);
    check_frame(16, 8, 4, 3'd4);

    // T4: bcnt 0 (no pop), bcnt 7 below minimum (1 pop), then 8-byte single-word frame
    p0 = dpop_n;
    b0 = bpop_n;
    push_words(15, 0, 1);
    push_words(5, 0, 1);
    push_bcnt(32'd0);
    push_bcnt(32'd7);
    push_bcnt(32'd8);
    wait_acc(25, 150, "t4");
    step(3);
    check("t4_data_pops", 64'(dpop_n - p0), 64'd2);
    check("t4_bcnt_pops", 64'(bpop_n - b0), 64'd3);
    check("t4_drop", 64'(stat_drop), 64'd3);
    check("t4_sent", 64'(stat_sent), 64'd4);
    check_frame(24, 1, 5, 3'd0);

    // T5: 64-byte frame with only 3 words present; the rest arrive 20 clk later
    u0 = und_n;
    push_words(6, 0, 3);
    push_bcnt(32'd64);
    step(20);
    push_words(6, 3, 5);
    wait_acc(33, 150, "t5");
    step(3);
    check("t5_underrun_pulses", 64'(und_n - u0), 64'd1);
    check_frame(25, 8, 6, 3'd0);
    check("t5_sent", 64'(stat_sent), 64'd5);

    // T6: two back-to-back 60-byte frames, inter-frame gap
    push_words(7, 0, 8);
    push_words(8, 0, 8);
    push_bcnt(32'd60);
    push_bcnt(32'd60);
    wait_acc(49, 200, "t6");
    step(3);
    check_frame(33, 8, 7, 3'd4);
    check_frame(41, 8, 8, 3'd4);
    check("t6_gap_ge6", 64'((acc_cyc[41] - acc_cyc[40]) >= 6), 64'd1);
    check("t6_sent", 64'(stat_sent), 64'd7);

    // T7: reset asserted mid-frame clears every output at once, then a clean frame
    push_words(9, 0, 8);
    push_bcnt(32'd64);
    wait_acc(51, 100, "t7");
    reset_ = 1'b0;
    #1;
    check("t7_rst_mac_flags", 64'({ifc.mac_tx_valid, ifc.mac_tx_sop, ifc.mac_tx_eop, ifc.mac_tx_mod}), 64'd0);
    check("t7_rst_mac_data", ifc.mac_tx_data, 64'd0);
    check("t7_rst_rdreq", 64'({ifc.txwbcnt_rdreq, ifc.txdata_rdreq}), 64'd0);
    check("t7_rst_stats", {stat_sent, stat_drop}, 64'd0);
    check("t7_rst_underrun", 64'(tx_underrun), 64'd0);
    step(2);
    reset_ = 1'b1;
    step(3);
    base = acc_n;
    push_words(10, 0, 8);
    push_bcnt(32'd64);
    wait_acc(base + 8, 100, "t7_post");
    step(3);
    check_frame(base, 8, 10, 3'd0);
    check("t7_post_stats", {stat_sent, stat_drop}, {32'd1, 32'd0});

    check("fifo_rules", 64'(viol_n), 64'd0);
    check("stall_stable_all", 64'(stall_viol_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
